// File: rtl/display_tx.sv
// display_tx -- LC-3 display output stage.
//
// Accepts stores to the Display Data Register (DDR) and sends the low byte
// of each stored word as a UART-style frame on txd. The frame is one start
// bit (0), eight data bits LSB first, and one stop bit (1). Each bit lasts
// CLK_DIV clocks. Characters are queued in a FIFO_DEPTH-entry FIFO, and the
// FIFO state is reported to software through DSR[15].
//
// Handshake: software must see dsr_ready=1 before it pulses ddr_wr. A
// ddr_wr that arrives while the FIFO is full (judged from the registered
// count before the edge) is dropped, and ovf pulses for one cycle. A pop on
// the same edge does not rescue that write. dsr_ready comes only from
// registered state, so there is no combinational path from ddr_wr to
// dsr_ready.
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   ddr_wr      one-cycle strobe: a DDR store has completed
//   ddr[15:0]   stored value; only [7:0] is sent
//   dsr[15:0]   {dsr_ready, 15'b0} for the IO read mux
//   dsr_ready   FIFO not full
//   txd         registered serial line; idles high
//   tx_busy     frame in progress or characters still queued
//   ovf         one-cycle pulse after a write is dropped
module display_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ddr_wr,
  input  logic [15:0] ddr,
  output logic [15:0] dsr,
  output logic        dsr_ready,
  output logic        txd,
  output logic        tx_busy,
  output logic        ovf
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [BW-1:0] baud, baud_d;
  logic [7:0]    shift, shift_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic          txd_d;
  logic          full, empty, push, pop, bit_end;
  logic          unused_hi;

  // The upper byte of DDR is never transmitted.
  assign unused_hi = ^ddr[15:8];

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = ddr_wr & ~full;
  assign bit_end   = (baud == BW'(CLK_DIV - 1));
  assign dsr_ready = ~full;
  assign dsr       = {dsr_ready, 15'b0};
  assign tx_busy   = (state != IDLE) | ~empty;

  // Next-state logic and the serialiser datapath.
  always_comb begin
    state_d   = state;
    baud_d    = baud;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    txd_d     = txd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          txd_d     = shift[0];
          state_d   = DATA;
        end else begin
          baud_d = baud + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            // Drive the next bit now. The register then holds the
            // already-shifted value.
            shift_d   = {1'b0, shift[7:1]};
            txd_d     = shift[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud + BW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      shift   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      shift   <= shift_d;
      bit_idx <= bit_idx_d;
      txd     <= txd_d;
    end
  end

  // FIFO bookkeeping. The contents need no reset because count=0 makes
  // them unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= ddr_wr & full;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ddr[7:0];
  end

endmodule

// File: tb/tb_display_tx.sv
// tb_display_tx -- directed bench for display_tx (CLK_DIV=4, FIFO_DEPTH=4).
// Stimulus pushes each accepted character into exp_q. A line monitor
// decodes every frame on txd, checks its shape, and compares the decoded
// byte against the head of exp_q. The main process checks cycle-exact
// timing of the status outputs.
module tb_display_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 10 * CLK_DIV;

  logic        clk, rst_n, ddr_wr;
  logic [15:0] ddr;
  logic [15:0] dsr;
  logic        dsr_ready, txd, tx_busy, ovf;

  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          cyc;
  int          n_checks;
  int          n_pass;

  display_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_wr(ddr_wr), .ddr(ddr), .dsr(dsr),
    .dsr_ready(dsr_ready), .txd(txd), .tx_busy(tx_busy), .ovf(ovf)
  );

  // Clock, cycle counter and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  // Driver: present a DDR store, sampled at the next rising edge. The task
  // returns 1 time unit after that edge.
  task automatic wr(input logic [15:0] d);
    @(negedge clk);
    ddr_wr = 1'b1;
    ddr    = d;
    @(posedge clk);
    #1 ddr_wr = 1'b0;
  endtask

  // Advance to 1 time unit after the edge where cyc reaches t.
  task automatic to_edge(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line monitor and scoreboard.
  initial begin : monitor
    logic s [FRAME];
    logic aborted, shape_ok;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          s[i] = txd;
        end
        if (!aborted) begin
          shape_ok = (s[0] == 1'b0) && (s[FRAME-CLK_DIV] == 1'b1);
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < CLK_DIV; k++)
              if (s[b*CLK_DIV+k] != s[b*CLK_DIV]) shape_ok = 1'b0;
          for (int j = 0; j < 8; j++) rx[j] = s[(j+1)*CLK_DIV];
          chk("frame_shape", {31'b0, shape_ok}, 32'd1);
          chk("frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) chk("rx_byte", {24'b0, rx}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin : stim
    int e0;
    logic flag;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    ddr_wr   = 1'b0;
    ddr      = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_dsr", {16'b0, dsr}, 32'h8000);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single character 0x41
    start_q.delete();
    exp_q.push_back(8'h41);
    wr(16'h0041);
    e0 = cyc;
    chk("single_txd_e0", {31'b0, txd}, 32'd1);
    chk("single_busy_e0", {31'b0, tx_busy}, 32'd1);
    to_edge(e0 + 1);
    chk("single_txd_e1", {31'b0, txd}, 32'd0);
    flag = 1'b1;
    while (cyc < e0 + 40) begin
      if (dsr_ready !== 1'b1) flag = 1'b0;
      to_edge(cyc + 1);
    end
    chk("single_ready_held", {31'b0, flag}, 32'd1);
    chk("single_busy_e40", {31'b0, tx_busy}, 32'd1);
    to_edge(e0 + 41);
    chk("single_busy_e41", {31'b0, tx_busy}, 32'd0);
    to_edge(e0 + 45);
    chk("single_nframes", start_q.size(), 32'd1);
    if (start_q.size() > 0) chk("single_start", start_q[0], e0 + 1);

    // Upper byte ignored
    exp_q.push_back(8'h55);
    wr(16'hAB55);
    to_edge(cyc + 45);

    // Overflow: 0x31..0x36 on consecutive edges, 0x36 dropped
    start_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h31 + 8'(i));
    wr(16'h0031);
    e0 = cyc;
    wr(16'h0032);
    wr(16'h0033);
    wr(16'h0034);
    chk("ovf_ready_e3", {31'b0, dsr_ready}, 32'd1);
    wr(16'h0035);
    chk("ovf_ready_e4", {31'b0, dsr_ready}, 32'd0);
    chk("ovf_dsr_e4", {16'b0, dsr}, 32'h0000);
    chk("ovf_pulse_e4", {31'b0, ovf}, 32'd0);
    wr(16'h0036);
    chk("ovf_pulse_e5", {31'b0, ovf}, 32'd1);
    to_edge(e0 + 6);
    chk("ovf_pulse_e6", {31'b0, ovf}, 32'd0);
    to_edge(e0 + 40);
    chk("ovf_ready_e40", {31'b0, dsr_ready}, 32'd0);
    to_edge(e0 + 41);
    chk("ovf_ready_e41", {31'b0, dsr_ready}, 32'd1);
    to_edge(e0 + 1 + 5 * FRAME + 4);
    chk("ovf_nframes", start_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < start_q.size()) chk("ovf_start", start_q[i], e0 + 1 + i * FRAME);
    chk("ovf_idle_busy", {31'b0, tx_busy}, 32'd0);

    // Back-to-back refill during the stop bit
    start_q.delete();
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
    wr(16'h000A);
    e0 = cyc;
    to_edge(e0 + 37);
    wr(16'h000D);
    to_edge(e0 + 1 + 2 * FRAME + 4);
    chk("b2b_nframes", start_q.size(), 32'd2);
    if (start_q.size() == 2) chk("b2b_gap", start_q[1] - start_q[0], FRAME);
    chk("sb_drained", exp_q.size(), 32'd0);

    // Reset during data bit 3 of 0x41 with two more characters queued
    start_q.delete();
    exp_q.push_back(8'h41);
    wr(16'h0041);
    e0 = cyc;
    wr(16'h0042);
    wr(16'h0043);
    to_edge(e0 + 18);
    chk("rst_pre_txd", {31'b0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", {31'b0, txd}, 32'd1);
    chk("rst_mid_dsr", {16'b0, dsr}, 32'h8000);
    chk("rst_mid_busy", {31'b0, tx_busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    flag = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) flag = 1'b0;
    end
    chk("post_rst_idle", {31'b0, flag}, 32'd1);
    chk("post_rst_nframes", start_q.size(), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_tx.md
# display_tx

Display output stage for the LC-3 device block: it consumes writes to the Display Data Register (DDR, 0xFE06) and serialises the low byte of each written word onto a UART-style line. It buffers characters in a small FIFO and drives the Display Status Register ready bit (DSR[15]) back to the memory/IO block. Software polls DSR[15] before each DDR store.

## Interface
Parameters:
- CLK_DIV, 16: clock cycles per serial bit; legal range ≥ 2.
- FIFO_DEPTH, 4: character buffer entries; a power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ddr_wr  in  1  one-cycle strobe: a DDR store has completed.
- ddr  in  16  DDR value sampled with ddr_wr; only [7:0] is transmitted, [15:8] is ignored.
- dsr  out  16  {dsr_ready, 15'b0}; feeds the IO mux at 0xFE04.
- dsr_ready  out  1  1 when the FIFO is not full.
- txd  out  1  serial output; idles high; registered.
- tx_busy  out  1  1 while a frame is on the line or the FIFO is non-empty.
- ovf  out  1  one-cycle pulse when a write is dropped because the FIFO is full.

## Operation
- Reset values: count=0, rd/wr pointers=0, state IDLE, txd=1, dsr_ready=1, dsr=16'h8000, tx_busy=0, ovf=0. Baud counter and shift register are cleared to 0.
- FIFO write: when ddr_wr=1 and count<FIFO_DEPTH, store ddr[7:0] at wr_ptr and increment wr_ptr. Pointers wrap modulo FIFO_DEPTH.
- Full check: uses the registered count from before the edge. If a write arrives while full, it is dropped and ovf pulses for one cycle, even if a pop happens on the same edge.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Each bit lasts exactly CLK_DIV cycles, so a frame is 10·CLK_DIV cycles.
- FSM states:
  - IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, load the baud counter with 0, set txd=0 and go to START.
  - START: when the baud counter reaches CLK_DIV-1, go to DATA with bit index 0 and drive txd=shift[0].
  - DATA: at each CLK_DIV-1, shift right and increment the bit index. After bit 7 completes, go to STOP and drive txd=1.
  - STOP: at CLK_DIV-1, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter: width clog2(CLK_DIV); resets to 0 on every bit boundary and never exceeds CLK_DIV-1.
- dsr_ready = (count != FIFO_DEPTH), derived from registered state with no combinational path from ddr_wr. dsr[14:0] is always 0.
- tx_busy = (state != IDLE) | (count != 0).

## Timing
- ddr_wr sampled at edge E0 with the FIFO empty and state IDLE: the pop happens at E1 and txd is low from E1.
- Start-bit falling edge to stop-bit end: 10·CLK_DIV cycles.
- Back-to-back characters: the next start bit begins on the edge that ends the previous stop bit.
- dsr_ready falls on the edge where count reaches FIFO_DEPTH. It rises on the edge of the next pop.
- ovf is asserted in the cycle after the dropped write's edge, for exactly one cycle.
- Reset asserted mid-frame: all outputs go immediately (asynchronously) to their reset values, and FIFO contents are discarded. No partial frame resumes after reset is released.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Single character: write 16'h0041 at E0 -> txd low from E1, then 40 cycles of 0,1,0,0,0,0,0,1,0,1 (4 cycles each). tx_busy returns to 0 at E41, dsr_ready stays 1 throughout.
- Upper byte ignored: write 16'hAB55 -> line carries 0x55 (0,1,0,1,0,1,0,1,0,1).
- Overflow: six writes 0x31..0x36 on consecutive edges E0..E5.
  - 0x31 pops at E1; 0x32..0x35 are buffered.
  - dsr_ready=0 after E4; 0x36 is dropped and ovf pulses once after E5.
  - Line carries 0x31..0x35 back-to-back with no gaps (200 cycles).
  - dsr_ready returns to 1 at E41.
- Back-to-back refill: write 0x0A, then write 0x0D during its stop bit -> the 0x0D start bit immediately follows the 0x0A stop bit.
- Reset mid-frame: deassert rst_n during data bit 3 of 0x41 with two more characters queued -> txd=1, dsr=16'h8000 and tx_busy=0 immediately. After release, the line stays idle high with no further frames.
